// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution with a hardware return-address stack.
// Define STACK_GUARD_EN to fault and halt on stack overflow/underflow instead of wrapping.
module pc_branch_unit #(
   parameter int                ADDR_W       = 16,
   parameter int                STACK_DEPTH  = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           STALL,
   input  logic                           JMP,
   input  logic                           JEZ,
   input  logic                           JEQ,
   input  logic                           JGT,
   input  logic                           JLT,
   input  logic                           CALL,
   input  logic                           RET,
   input  logic [ADDR_W-1:0]              TARGET,
   input  logic                           FLAG_ZERO,
   input  logic                           FLAG_EQUAL,
   input  logic                           FLAG_GREATER_THAN,
   input  logic                           FLAG_LESS_THAN,
   output logic [ADDR_W-1:0]              PC,
   output logic                           TAKEN,
   output logic [$clog2(STACK_DEPTH):0]   STACK_COUNT,
   output logic                           FAULT
);

   localparam int               PTR_W    = $clog2(STACK_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

`ifdef STACK_GUARD_EN
   localparam bit GUARD_EN = 1'b1;
`else
   localparam bit GUARD_EN = 1'b0;
`endif

   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
   logic              taken_q, taken_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic              fault_q, fault_d;
   logic              push_en;
   logic              jump_hit;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   always_comb begin
      pc_inc   = pc_q + ADDR_W'(1);
      ptr_inc  = ptr_q + PTR_W'(1);
      ptr_dec  = ptr_q - PTR_W'(1);
      jump_hit = JMP | (JEZ & FLAG_ZERO) | (JEQ & FLAG_EQUAL)
               | (JGT & FLAG_GREATER_THAN) | (JLT & FLAG_LESS_THAN);
      pc_d     = pc_q;
      taken_d  = taken_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      fault_d  = fault_q;
      push_en  = 1'b0;
      // A raised fault is a halt: nothing but reset moves the state again.
      if (!STALL && !fault_q) begin
         if (RET) begin
            if (GUARD_EN && cnt_q == '0) begin
               fault_d = 1'b1;
               taken_d = 1'b0;
            end else begin
               pc_d    = stack_mem[ptr_dec];
               ptr_d   = ptr_dec;
               taken_d = 1'b1;
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
         end else if (CALL) begin
            if (GUARD_EN && cnt_q == CNT_FULL) begin
               fault_d = 1'b1;
               taken_d = 1'b0;
            end else begin
               push_en = 1'b1;
               pc_d    = TARGET;
               ptr_d   = ptr_inc;
               taken_d = 1'b1;
               if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (jump_hit) begin
            pc_d    = TARGET;
            taken_d = 1'b1;
         end else begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q    <= RESET_VECTOR;
         taken_q <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         taken_q <= taken_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         fault_q <= fault_d;
      end
   end

   // Stack RAM is not reset; a reset edge still suppresses a pending push.
   always_ff @(posedge CLK) begin
      if (!RST && push_en) stack_mem[ptr_q] <= pc_inc;
   end

   assign PC          = pc_q;
   assign TAKEN       = taken_q;
   assign STACK_COUNT = cnt_q;
`ifdef STACK_GUARD_EN
   assign FAULT = fault_q;
`else
   assign FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against a behavioural model.
module tb_pc_branch_unit;

   localparam int D  = 8;
   localparam int RV = 'h0100;
`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST, STALL, JMP, JEZ, JEQ, JGT, JLT, CALL, RET;
   logic [15:0] TARGET;
   logic        FLAG_ZERO, FLAG_EQUAL, FLAG_GREATER_THAN, FLAG_LESS_THAN;
   logic [15:0] PC;
   logic        TAKEN;
   logic [3:0]  STACK_COUNT;
   logic        FAULT;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: return addresses in a circular memory addressed mod D.
   int m_pc, m_taken, m_cnt, m_ptr, m_fault;
   int m_mem [D];
   bit m_init [D];

   pc_branch_unit #(.ADDR_W(16), .STACK_DEPTH(D), .RESET_VECTOR(16'h0100)) dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .JMP(JMP), .JEZ(JEZ), .JEQ(JEQ),
      .JGT(JGT), .JLT(JLT), .CALL(CALL), .RET(RET), .TARGET(TARGET),
      .FLAG_ZERO(FLAG_ZERO), .FLAG_EQUAL(FLAG_EQUAL),
      .FLAG_GREATER_THAN(FLAG_GREATER_THAN), .FLAG_LESS_THAN(FLAG_LESS_THAN),
      .PC(PC), .TAKEN(TAKEN), .STACK_COUNT(STACK_COUNT), .FAULT(FAULT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      RST = 0; STALL = 0; JMP = 0; JEZ = 0; JEQ = 0; JGT = 0; JLT = 0;
      CALL = 0; RET = 0; TARGET = 16'h0;
      FLAG_ZERO = 0; FLAG_EQUAL = 0; FLAG_GREATER_THAN = 0; FLAG_LESS_THAN = 0;
   endtask

   task automatic model_step();
      bit cond;
      cond = JMP || (JEZ && FLAG_ZERO) || (JEQ && FLAG_EQUAL)
          || (JGT && FLAG_GREATER_THAN) || (JLT && FLAG_LESS_THAN);
      if (RST) begin
         m_pc = RV; m_taken = 0; m_cnt = 0; m_ptr = 0; m_fault = 0;
      end else if (!STALL && !m_fault) begin
         if (RET) begin
            if (GUARD && m_cnt == 0) begin
               m_fault = 1; m_taken = 0;
            end else begin
               m_ptr   = (m_ptr + D - 1) % D;
               m_pc    = m_mem[m_ptr];
               m_cnt   = (m_cnt > 0) ? m_cnt - 1 : 0;
               m_taken = 1;
            end
         end else if (CALL) begin
            if (GUARD && m_cnt == D) begin
               m_fault = 1; m_taken = 0;
            end else begin
               m_mem[m_ptr]  = (m_pc + 1) % 65536;
               m_init[m_ptr] = 1;
               m_ptr   = (m_ptr + 1) % D;
               m_cnt   = (m_cnt < D) ? m_cnt + 1 : D;
               m_pc    = int'(TARGET);
               m_taken = 1;
            end
         end else if (cond) begin
            m_pc = int'(TARGET); m_taken = 1;
         end else begin
            m_pc = (m_pc + 1) % 65536; m_taken = 0;
         end
      end
   endtask

   // One clock: advance model with the driven inputs, then compare after the edge.
   task automatic cyc();
      model_step();
      @(posedge CLK);
      #1;
      chk("pc", 32'(PC), 32'(m_pc));
      chk("taken", 32'(TAKEN), 32'(m_taken));
      chk("count", 32'(STACK_COUNT), 32'(m_cnt));
      chk("fault", 32'(FAULT), 32'(m_fault));
   endtask

   task automatic jmp_to(input logic [15:0] a);
      clr(); JMP = 1; TARGET = a; cyc(); clr();
   endtask

   initial begin
      for (int i = 0; i < D; i++) begin m_mem[i] = 0; m_init[i] = 0; end
      m_pc = 0; m_taken = 0; m_cnt = 0; m_ptr = 0; m_fault = 0;
      clr();
      RST = 1; cyc();
      chk("rst_pc", 32'(PC), 32'h0100);
      chk("rst_cnt", 32'(STACK_COUNT), 32'h0);
      clr();
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("idle_pc", 32'(PC), 32'(16'h0100 + i));
         chk("idle_taken", 32'(TAKEN), 32'h0);
      end

      // conditional jump, flag false then true
      jmp_to(16'h0010);
      JEQ = 1; TARGET = 16'h0200; FLAG_EQUAL = 0; FLAG_ZERO = 1; cyc();
      chk("jeq_f_pc", 32'(PC), 32'h0011);
      chk("jeq_f_taken", 32'(TAKEN), 32'h0);
      FLAG_EQUAL = 1; cyc();
      chk("jeq_t_pc", 32'(PC), 32'h0200);
      chk("jeq_t_taken", 32'(TAKEN), 32'h1);

      // nested call/return
      jmp_to(16'h0020);
      CALL = 1; TARGET = 16'h0300; cyc(); chk("call1", 32'(PC), 32'h0300);
      TARGET = 16'h0400; cyc(); chk("call2", 32'(PC), 32'h0400);
      chk("call2_cnt", 32'(STACK_COUNT), 32'h2);
      clr(); RET = 1; cyc(); chk("ret1", 32'(PC), 32'h0301);
      cyc(); chk("ret2", 32'(PC), 32'h0021);
      chk("ret2_cnt", 32'(STACK_COUNT), 32'h0);

      // RET outranks CALL and JMP; STALL holds everything
      jmp_to(16'h0054);
      CALL = 1; TARGET = 16'h0999; cyc();
      clr(); CALL = 1; RET = 1; JMP = 1; TARGET = 16'h0777; cyc();
      chk("prio_pc", 32'(PC), 32'h0055);
      chk("prio_cnt", 32'(STACK_COUNT), 32'h0);
      clr(); STALL = 1; JMP = 1; TARGET = 16'h0abc; cyc();
      chk("stall_pc", 32'(PC), 32'h0055);

      // address wrap on increment and on pushed return address
      jmp_to(16'hFFFF);
      cyc(); chk("wrap_pc", 32'(PC), 32'h0000);
      jmp_to(16'hFFFF);
      CALL = 1; TARGET = 16'h1234; cyc();
      clr(); RET = 1; cyc(); chk("wrap_ret", 32'(PC), 32'h0000);

      // reset wins over a concurrent call
      clr(); RST = 1; CALL = 1; TARGET = 16'h4444; cyc();
      chk("rst_call_cnt", 32'(STACK_COUNT), 32'h0);

      // nine calls into an eight-deep stack
      jmp_to(16'h1000);
      for (int k = 0; k < 9; k++) begin
         clr(); CALL = 1; TARGET = 16'(16'h2000 + k * 16); cyc();
      end
      chk("full_cnt", 32'(STACK_COUNT), 32'h8);
      chk("full_fault", 32'(FAULT), 32'(GUARD));
      chk("full_pc", 32'(PC), GUARD ? 32'h2070 : 32'h2080);
      for (int j = 0; j < 8; j++) begin
         clr(); RET = 1; cyc();
         chk("unwind_pc", 32'(PC), GUARD ? 32'h2070 : 32'(16'h2000 + (7 - j) * 16 + 1));
      end

      // randomized traffic against the model
      clr(); RST = 1; cyc();
      for (int i = 0; i < 600; i++) begin
         clr();
         RST    = ($urandom_range(0, 99) < 2);
         STALL  = ($urandom_range(0, 9) == 0);
         JMP    = ($urandom_range(0, 7) == 0);
         JEZ    = ($urandom_range(0, 3) == 0);
         JEQ    = ($urandom_range(0, 3) == 0);
         JGT    = ($urandom_range(0, 3) == 0);
         JLT    = ($urandom_range(0, 3) == 0);
         CALL   = ($urandom_range(0, 5) == 0);
         RET    = ($urandom_range(0, 5) == 0);
         TARGET = 16'($urandom);
         FLAG_ZERO         = 1'($urandom);
         FLAG_EQUAL        = 1'($urandom);
         FLAG_GREATER_THAN = 1'($urandom);
         FLAG_LESS_THAN    = 1'($urandom);
         // never pop a slot that has not been written since power-up
         if (RET && !m_init[(m_ptr + D - 1) % D] && !(GUARD && m_cnt == 0)) RET = 0;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
